// File: rtl/sfx_if.sv
// Request/tone bus between the event logic (master) and the sfx scheduler (slave).
// The master raises req edges with sfx codes; the slave drives the 4-voice tone outputs.
interface sfx_if;
  logic [3:0]  req;
  logic [15:0] sfx0;
  logic [15:0] sfx1;
  logic [15:0] sfx2;
  logic [15:0] sfx3;
  logic [3:0]  t0;
  logic [3:0]  t1;
  logic [3:0]  t2;
  logic [3:0]  t3;
  logic        busy;
  logic [1:0]  active_id;
  logic        done;

  modport master (
    output req, sfx0, sfx1, sfx2, sfx3,
    input  t0, t1, t2, t3, busy, active_id, done
  );

  modport slave (
    input  req, sfx0, sfx1, sfx2, sfx3,
    output t0, t1, t2, t3, busy, active_id, done
  );
endinterface

// File: rtl/sfx_scheduler.sv
// Fixed-priority scheduler that plays one queued sound effect at a time on the tone bus,
// with optional preemption of lower-priority effects and a silent gap after completion.
module sfx_scheduler #(
  parameter logic [31:0] MAIN_CLK_SPEED = 32'd12_288_000,
  parameter logic [31:0] PLAY_DIV       = 32'd10,
  parameter logic [31:0] GAP_TICKS      = 32'd0,
  parameter bit          PREEMPT        = 1'b1
) (
  input logic clk,
  input logic reset,
  sfx_if.slave bus
);

  localparam logic [31:0] PLAY_RAW   = (PLAY_DIV == 32'd0) ? 32'd0 : MAIN_CLK_SPEED / PLAY_DIV;
  localparam logic [31:0] PLAY_TICKS = (PLAY_RAW == 32'd0) ? 32'd1 : PLAY_RAW;

  typedef enum logic [1:0] {
    IDLE,
    PLAY,
    GAP
  } state_t;

  state_t      state;
  logic [3:0]  req_q;
  logic [3:0]  pending;
  logic [15:0] code [4];
  logic [31:0] counter;
  logic [15:0] tone_q;
  logic        busy_q;
  logic [1:0]  active_q;
  logic        done_q;

  logic [15:0] sfx_in [4];
  logic [3:0]  req_edge;
  logic [1:0]  sel;
  logic        start;
  logic [3:0]  grant_mask;

  assign sfx_in[0] = bus.sfx0;
  assign sfx_in[1] = bus.sfx1;
  assign sfx_in[2] = bus.sfx2;
  assign sfx_in[3] = bus.sfx3;

  assign req_edge = bus.req & ~req_q;

  // Lowest set index of the registered pending vector wins; scanning downward lets it overwrite.
  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    sel = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (pending[i]) sel = 2'(i);
    end
  end

  // A grant happens from IDLE, or from PLAY when a strictly higher-priority request is waiting.
  always_comb begin
    start = 1'b0;
    if (pending != 4'b0) begin
      if (state == IDLE) start = 1'b1;
      else if (PREEMPT && state == PLAY && sel < active_q) start = 1'b1;
    end
    grant_mask = start ? (4'b0001 << sel) : 4'b0000;
  end

  // NOTE: all state below is sequential and uses non-blocking assignments only, so every
  // read in this block sees the value from before the clock edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      req_q    <= bus.req;
      pending  <= 4'b0;
      counter  <= 32'd0;
      tone_q   <= 16'h0000;
      busy_q   <= 1'b0;
      active_q <= 2'd0;
      done_q   <= 1'b0;
      // NOTE: the four code slots form a tiny register file, so they are reset like any flop.
      for (int i = 0; i < 4; i++) code[i] <= 16'h0000;
    end else begin
      req_q   <= bus.req;
      done_q  <= 1'b0;
      // A new edge on a channel being granted this cycle keeps it pending (set wins).
      pending <= (pending & ~grant_mask) | req_edge;
      for (int i = 0; i < 4; i++) begin
        if (req_edge[i]) code[i] <= sfx_in[i];
      end

      if (start) begin
        state    <= PLAY;
        tone_q   <= code[sel];
        active_q <= sel;
        counter  <= 32'd0;
        busy_q   <= 1'b1;
      end else begin
        case (state)
          PLAY: begin
            if (counter == PLAY_TICKS - 32'd1) begin
              tone_q  <= 16'h0000;
              done_q  <= 1'b1;
              counter <= 32'd0;
              if (GAP_TICKS != 32'd0) begin
                state  <= GAP;
                busy_q <= 1'b1;
              end else begin
                state  <= IDLE;
                busy_q <= 1'b0;
              end
            end else begin
              counter <= counter + 32'd1;
            end
          end
          GAP: begin
            if (counter == GAP_TICKS - 32'd1) begin
              state   <= IDLE;
              busy_q  <= 1'b0;
              counter <= 32'd0;
            end else begin
              counter <= counter + 32'd1;
            end
          end
          default: begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.t0        = tone_q[15:12];
  assign bus.t1        = tone_q[11:8];
  assign bus.t2        = tone_q[7:4];
  assign bus.t3        = tone_q[3:0];
  assign bus.busy      = busy_q;
  assign bus.active_id = active_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_sfx_scheduler.sv
// Self-checking bench: two schedulers (preempting and non-preempting) share one stimulus
// and are compared every cycle against a countdown-based behavioural model.
module tb_sfx_scheduler;

  localparam int PT  = 10;
  localparam int GAP = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  req = 4'b0;
  logic [15:0] sfx [4] = '{16'h0, 16'h0, 16'h0, 16'h0};

  int checks = 0;
  int errors = 0;

  sfx_if bus_a ();
  sfx_if bus_b ();

  assign bus_a.req  = req;
  assign bus_a.sfx0 = sfx[0];
  assign bus_a.sfx1 = sfx[1];
  assign bus_a.sfx2 = sfx[2];
  assign bus_a.sfx3 = sfx[3];
  assign bus_b.req  = req;
  assign bus_b.sfx0 = sfx[0];
  assign bus_b.sfx1 = sfx[1];
  assign bus_b.sfx2 = sfx[2];
  assign bus_b.sfx3 = sfx[3];

  sfx_scheduler #(
    .MAIN_CLK_SPEED(32'd100), .PLAY_DIV(32'd10), .GAP_TICKS(32'd2), .PREEMPT(1'b1)
  ) dut_a (
    .clk(clk), .reset(reset), .bus(bus_a)
  );

  sfx_scheduler #(
    .MAIN_CLK_SPEED(32'd100), .PLAY_DIV(32'd10), .GAP_TICKS(32'd2), .PREEMPT(1'b0)
  ) dut_b (
    .clk(clk), .reset(reset), .bus(bus_b)
  );

  always #5 clk = ~clk;

  // Observed outputs packed as {t0,t1,t2,t3,busy,active_id,done}.
  logic [19:0] obs [2];
  assign obs[0] = {bus_a.t0, bus_a.t1, bus_a.t2, bus_a.t3, bus_a.busy, bus_a.active_id, bus_a.done};
  assign obs[1] = {bus_b.t0, bus_b.t1, bus_b.t2, bus_b.t3, bus_b.busy, bus_b.active_id, bus_b.done};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: play_left counts tone cycles still to show, gap_left silent busy cycles.
  bit          m_preempt [2] = '{1'b1, 1'b0};
  logic [3:0]  m_pend [2];
  logic [15:0] m_code [2][4];
  logic [3:0]  m_prev [2];
  int          m_play [2];
  int          m_gap [2];
  logic [15:0] e_tone [2];
  logic        e_busy [2];
  logic [1:0]  e_act [2];
  logic        e_done [2];

  task automatic model_step(input int k);
    logic [3:0] edges;
    int win;
    edges = req & ~m_prev[k];
    if (reset) begin
      m_pend[k] = 4'b0;
      for (int i = 0; i < 4; i++) m_code[k][i] = 16'h0;
      m_play[k] = 0;
      m_gap[k]  = 0;
      e_tone[k] = 16'h0;
      e_busy[k] = 1'b0;
      e_act[k]  = 2'd0;
      e_done[k] = 1'b0;
    end else begin
      win = -1;
      for (int i = 0; i < 4; i++) if (m_pend[k][i] && win < 0) win = i;
      e_done[k] = 1'b0;
      if (win >= 0 && ((m_play[k] == 0 && m_gap[k] == 0) ||
                       (m_preempt[k] && m_play[k] > 0 && win < int'(e_act[k])))) begin
        e_act[k]       = 2'(win);
        e_tone[k]      = m_code[k][win];
        m_play[k]      = PT;
        m_gap[k]       = 0;
        m_pend[k][win] = 1'b0;
      end else if (m_play[k] > 0) begin
        m_play[k]--;
        if (m_play[k] == 0) begin
          e_tone[k] = 16'h0;
          e_done[k] = 1'b1;
          m_gap[k]  = GAP;
        end
      end else if (m_gap[k] > 0) begin
        m_gap[k]--;
      end
      e_busy[k] = (m_play[k] > 0) || (m_gap[k] > 0);
      for (int i = 0; i < 4; i++) begin
        if (edges[i]) begin
          m_pend[k][i] = 1'b1;
          m_code[k][i] = sfx[i];
        end
      end
    end
    m_prev[k] = req;
  endtask

  // Per-scenario counters of cycles showing watched codes and of done pulses.
  logic [15:0] watch0 = 16'h0, watch1 = 16'h0;
  int cnt0 [2], cnt1 [2], cntd [2];

  task automatic clear_counts();
    for (int k = 0; k < 2; k++) begin
      cnt0[k] = 0;
      cnt1[k] = 0;
      cntd[k] = 0;
    end
  endtask

  initial begin
    clear_counts();
    forever begin
      @(posedge clk);
      model_step(0);
      model_step(1);
      #2;
      check("cycle_dut_preempt", 32'(obs[0]), 32'({e_tone[0], e_busy[0], e_act[0], e_done[0]}));
      check("cycle_dut_nopreempt", 32'(obs[1]), 32'({e_tone[1], e_busy[1], e_act[1], e_done[1]}));
      for (int k = 0; k < 2; k++) begin
        if (obs[k][19:4] == watch0) cnt0[k]++;
        if (obs[k][19:4] == watch1) cnt1[k]++;
        if (obs[k][0]) cntd[k]++;
      end
    end
  end

  task automatic pulse(input int i, input logic [15:0] code);
    @(negedge clk);
    sfx[i] = code;
    req[i] = 1'b1;
    @(negedge clk);
    req[i] = 1'b0;
  endtask

  task automatic settle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    settle(3);
    reset = 1'b0;
    settle(2);
    check("reset_outputs", 32'(obs[0]), 32'h0);

    // Single effect: tones one cycle after the pulse returns, 10 cycles, one done.
    watch0 = 16'h1234; watch1 = 16'hFFFF;
    clear_counts();
    pulse(2, 16'h1234);
    @(negedge clk);
    check("single_tones", 32'(obs[0][19:4]), 32'h1234);
    check("single_active", 32'(obs[0][2:1]), 32'd2);
    settle(25);
    check("single_len", cnt0[0], 10);
    check("single_done", cntd[0], 1);
    check("single_idle", 32'(obs[0][3]), 32'd0);

    // Priority: 1 before 3 when both rise together.
    watch0 = 16'hAAAA; watch1 = 16'h5555;
    clear_counts();
    @(negedge clk);
    sfx[1] = 16'hAAAA; sfx[3] = 16'h5555; req = 4'b1010;
    @(negedge clk);
    req = 4'b0000;
    @(negedge clk);
    check("prio_first", 32'(obs[0][19:4]), 32'hAAAA);
    settle(40);
    check("prio_len1", cnt0[0], 10);
    check("prio_len3", cnt1[0], 10);
    check("prio_done", cntd[0], 2);

    // Preemption of 3 by 0 partway through; the non-preempting copy lets 3 finish.
    watch0 = 16'h5555; watch1 = 16'hF00F;
    clear_counts();
    pulse(3, 16'h5555);
    settle(3);
    pulse(0, 16'hF00F);
    settle(45);
    check("preempt_cut", cnt0[0], 5);
    check("preempt_new", cnt1[0], 10);
    check("preempt_done", cntd[0], 1);
    check("nopreempt_full", cnt0[1], 10);
    check("nopreempt_new", cnt1[1], 10);
    check("nopreempt_done", cntd[1], 2);

    // Overwrite while pending: only the latest code plays.
    watch0 = 16'h1111; watch1 = 16'h2222;
    clear_counts();
    pulse(0, 16'h0C0C);
    settle(2);
    pulse(2, 16'h1111);
    pulse(2, 16'h2222);
    settle(45);
    check("overwrite_old", cnt0[0], 0);
    check("overwrite_new", cnt1[0], 10);

    // Retrigger of the active channel replays it once.
    watch0 = 16'h7777; watch1 = 16'hFFFF;
    clear_counts();
    pulse(0, 16'h7777);
    settle(3);
    pulse(0, 16'h7777);
    settle(45);
    check("retrig_len", cnt0[0], 20);
    check("retrig_done", cntd[0], 2);

    // Reset mid-play with req[1] held: silence, then no replay until a fresh edge.
    watch0 = 16'h4321;
    @(negedge clk);
    sfx[1] = 16'h4321; req[1] = 1'b1;
    settle(5);
    check("rst_playing", 32'(obs[0][19:4]), 32'h4321);
    reset = 1'b1;
    @(negedge clk);
    check("rst_silent", 32'(obs[0]), 32'h0);
    settle(2);
    reset = 1'b0;
    clear_counts();
    settle(30);
    check("rst_no_fire", cnt0[0], 0);
    req[1] = 1'b0;
    pulse(1, 16'h4321);
    settle(30);
    check("rst_refire", cnt0[0], 10);

    // A level held for 50 cycles plays once.
    watch0 = 16'h9999;
    clear_counts();
    @(negedge clk);
    sfx[2] = 16'h9999; req[2] = 1'b1;
    settle(50);
    req[2] = 1'b0;
    settle(20);
    check("held_len", cnt0[0], 10);
    check("held_done", cntd[0], 1);

    // Randomized traffic with occasional resets, checked cycle by cycle.
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        if ($urandom_range(0, 7) == 0) begin
          req[i] = ~req[i];
          if (req[i]) sfx[i] = 16'($urandom);
        end
      end
      reset = ($urandom_range(0, 399) == 0);
    end
    reset = 1'b0;
    req = 4'b0;
    settle(40);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sfx_scheduler.md
Name: sfx_scheduler

Overview:
Arbitrates four sound-effect requesters onto the single 4-voice tone bus (t0..t3) feeding the synth voices. Each requester edge-triggers a 16-bit sfx code (four 4-bit tone indices); the scheduler queues one pending request per source and plays them one at a time for a fixed duration, in fixed priority order. Optional preemption lets a higher-priority effect cut off a lower one. Sits between game/UI event logic and the tone generators.

Parameters:
MAIN_CLK_SPEED, 32'd12_288_000, clk frequency in Hz
PLAY_DIV, 32'd10, play duration PLAY_TICKS = MAIN_CLK_SPEED/PLAY_DIV cycles (a result of 0 is treated as 1)
GAP_TICKS, 32'd0, silent cycles inserted after each normally completed effect
PREEMPT, 1'b1, 1 = higher-priority pending request aborts current effect

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
req  in  4  request lines; a rising edge on req[i] issues a request; index 0 is highest priority
sfx0  in  16  code for requester 0 ([15:12]->t0, [11:8]->t1, [7:4]->t2, [3:0]->t3)
sfx1  in  16  code for requester 1
sfx2  in  16  code for requester 2
sfx3  in  16  code for requester 3
t0  out  4  tone voice 0; registered; 0 when not playing
t1  out  4  tone voice 1
t2  out  4  tone voice 2
t3  out  4  tone voice 3
busy  out  1  high in PLAY or GAP
active_id  out  2  index of the effect playing; holds its last value otherwise
done  out  1  one-cycle pulse when an effect completes its full duration

Behaviour:
- Reset (sync, active-high): state=IDLE, pending=0, codes=0, counter=0, t0..t3=0, busy=0, active_id=0, done=0. req_q loads req, so lines held high through reset do not fire.
- Edge detect: req[i] & ~req_q[i] at a clock edge sets pending[i] and captures sfx_i into code[i]. A repeat edge while pending overwrites code[i] (latest wins).
- Arbitration: lowest-index set bit of the registered pending vector. Edges detected in the same cycle are not arbitrated until the next cycle.
- States: IDLE, PLAY, GAP.
- IDLE -> PLAY when pending!=0. On that edge: load t0..t3 from code[sel], set active_id=sel, clear pending[sel], clear counter, set busy=1.
- Latency: req sampled high at edge E0 sets pending. Tones appear after E1 when the scheduler is IDLE.
- PLAY: counter increments each cycle. When counter==PLAY_TICKS-1:
  - t0..t3 go to 0 and done pulses for 1 cycle.
  - Go to GAP if GAP_TICKS>0, else IDLE.
  - Tones are therefore driven for exactly PLAY_TICKS cycles.
- GAP: outputs 0, busy=1. Counts GAP_TICKS cycles, then goes to IDLE. Back-to-back effects are separated by GAP_TICKS+1 silent cycles.
- Preemption (PREEMPT=1): in PLAY, if the arbitration winner j < active_id, reload at the next edge as from IDLE (new code, counter=0, active_id=j, clear pending[j]).
  - The aborted effect is dropped, not requeued, and produces no done pulse.
  - Preemption takes priority over normal completion in the same cycle.
- PREEMPT=0: pending requests wait until the current effect (and its gap) finish.
- Same-channel retrigger: an edge on active_id during PLAY sets pending, and the effect replays after the current one. If an edge on channel i coincides with the grant of i, the set wins and pending[i] stays 1.
- Counter is 32-bit and never wraps within PLAY_TICKS. Reset mid-PLAY silences tones at the next edge.

Test Plan:
Bench parameters: MAIN_CLK_SPEED=100, PLAY_DIV=10 (PLAY_TICKS=10), GAP_TICKS=2, PREEMPT=1 unless noted.
- Single: sfx2=16'h1234, pulse req[2] -> t0..t3=1,2,3,4 for exactly 10 cycles starting 2 cycles after the req edge; active_id=2; one done pulse; then 2 GAP cycles plus 1 IDLE cycle, then busy=0.
- Priority: req[3] and req[1] rise in the same cycle (sfx1=16'hAAAA, sfx3=16'h5555) -> AAAA plays first, done; after 3 silent cycles, 5555 plays; two done pulses.
- Preempt: req[3] (16'h5555) is playing at counter=4 when req[0] rises (16'hF00F) -> F00F appears 2 cycles later with a full 10 cycles; no done for 3; requester 3 never resumes. Same stimulus with PREEMPT=0 -> 5555 completes all 10 cycles, then F00F plays.
- Overwrite/retrigger: while 0 plays, pulse req[2] with 16'h1111 then with 16'h2222 -> only 2222 plays afterwards, once. Pulse req[0] during its own play -> it replays once.
- Reset: assert reset mid-PLAY with req[1] held high -> outputs 0 the next cycle; after release, no effect plays until req[1] falls and rises again.
- Held request: keep req[2] high for 50 cycles -> exactly one effect plays (edge-triggered).
